// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: shared writeback request type and read-hazard helper.
package riscv_wb_pkg;
  localparam int WB_ADDR_WIDTH = 6;
  localparam int WB_DATA_WIDTH = 32;
  typedef logic [WB_ADDR_WIDTH-1:0] wb_addr_t;
  typedef struct packed {
    logic                     we;
    wb_addr_t                 waddr;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } wb_req_t;
  // x0 is never written, so it can never be a pending-write hazard
  function automatic logic rd_hit(input wb_addr_t ra, input wb_addr_t rb, input wb_addr_t rc,
                                  input logic v, input wb_addr_t w);
    return v && (w != '0) && (ra == w || rb == w || rc == w);
  endfunction
endpackage

// File: rtl/riscv_wb_fifo.sv
// riscv_wb_fifo: small APU result buffer exposing per-entry valid bits and addresses.
module riscv_wb_fifo import riscv_wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_clr,
  input  logic                                 i_push,
  input  logic                                 i_pop,
  input  wb_req_t                              i_req,
  output wb_req_t                              o_head,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic [DEPTH-1:0]                     o_vld,
  output logic [DEPTH-1:0][WB_ADDR_WIDTH-1:0]  o_addr
);
  localparam int PW = $clog2(DEPTH);
  wb_req_t          r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_cnt;
  logic [DEPTH-1:0] r_vld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
      if (i_pop) r_vld[r_rptr] <= 1'b0;
      if (i_push) r_vld[r_wptr] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_req;
  end
  always_comb begin
    o_addr = '0;
    for (int i = 0; i < DEPTH; i++) o_addr[i] = r_mem[i].waddr;
  end
  assign o_head  = r_mem[r_rptr];
  assign o_full  = r_cnt == (PW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_vld   = r_vld;
endmodule

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: merges EX, LSU and APU results onto two registered register-file write ports.
module riscv_wb_arbiter import riscv_wb_pkg::*; #(
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int APU_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  setback_i,
  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  lsu_we_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic                  apu_valid_i,
  input  logic [ADDR_WIDTH-1:0] apu_waddr_i,
  input  logic [DATA_WIDTH-1:0] apu_wdata_i,
  output logic                  apu_ready_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  hazard_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o
);
  logic    w_full, w_empty, w_ex_v, w_lsu_v, w_apu_xfer, w_apu_nz, w_bypass, w_push, w_pop, w_coll, w_hz;
  logic [APU_FIFO_DEPTH-1:0]                    w_vld;
  logic [APU_FIFO_DEPTH-1:0][WB_ADDR_WIDTH-1:0] w_faddr;
  wb_req_t w_head, w_apu_req, w_b, w_a_nxt, w_b_nxt;
  wb_req_t r_a, r_b;
  assign w_ex_v     = ex_we_i && ex_waddr_i != '0;
  assign w_lsu_v    = lsu_we_i && lsu_waddr_i != '0;
  assign apu_ready_o = !w_full;
  assign w_apu_xfer = apu_valid_i && !w_full;
  assign w_apu_nz   = w_apu_xfer && apu_waddr_i != '0;
  assign w_bypass   = w_apu_nz && w_empty && !w_lsu_v;
  assign w_push     = w_apu_nz && !w_bypass && !setback_i;
  assign w_pop      = !w_empty && !w_lsu_v && !setback_i;
  assign w_apu_req  = wb_req_t'{we: w_bypass, waddr: apu_waddr_i, wdata: apu_wdata_i};
  // Port-B candidate: LSU first, then buffered APU results, then APU bypass
  assign w_b = w_lsu_v  ? wb_req_t'{we: 1'b1, waddr: lsu_waddr_i, wdata: lsu_wdata_i} :
               !w_empty ? w_head : w_apu_req;
  // EX is the younger write to the same register; the older port-B result is discarded
  assign w_coll  = w_ex_v && ex_waddr_i == w_b.waddr;
  assign w_a_nxt = w_ex_v ? wb_req_t'{we: 1'b1, waddr: ex_waddr_i, wdata: ex_wdata_i} : '0;
  assign w_b_nxt = (w_b.we && !w_coll) ? w_b : '0;
  riscv_wb_fifo #(.DEPTH(APU_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (setback_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_req   (wb_req_t'{we: 1'b1, waddr: apu_waddr_i, wdata: apu_wdata_i}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_vld   (w_vld),
    .o_addr  (w_faddr)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= setback_i ? '0 : w_a_nxt;
      r_b <= setback_i ? '0 : w_b_nxt;
    end
  end
  always_comb begin
    w_hz = rd_hit(raddr_a_i, raddr_b_i, raddr_c_i, r_a.we, r_a.waddr) |
           rd_hit(raddr_a_i, raddr_b_i, raddr_c_i, r_b.we, r_b.waddr);
    for (int i = 0; i < APU_FIFO_DEPTH; i++)
      w_hz = w_hz | rd_hit(raddr_a_i, raddr_b_i, raddr_c_i, w_vld[i], w_faddr[i]);
  end
  assign hazard_o  = w_hz;
  assign we_a_o    = r_a.we;
  assign waddr_a_o = r_a.waddr;
  assign wdata_a_o = r_a.wdata;
  assign we_b_o    = r_b.we;
  assign waddr_b_o = r_b.waddr;
  assign wdata_b_o = r_b.wdata;
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb_riscv_wb_arbiter: directed vector table plus reset/setback sequences for the writeback arbiter.
module tb_riscv_wb_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, setback_i = 1'b0;
  logic        ex_we_i, lsu_we_i, apu_valid_i, apu_ready_o, hazard_o, we_a_o, we_b_o;
  logic [5:0]  ex_waddr_i, lsu_waddr_i, apu_waddr_i, raddr_a_i, raddr_b_i, raddr_c_i, waddr_a_o, waddr_b_o;
  logic [31:0] ex_wdata_i, lsu_wdata_i, apu_wdata_i, wdata_a_o, wdata_b_o;
  always #5 clk = ~clk;
  riscv_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .setback_i(setback_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .apu_valid_i(apu_valid_i), .apu_waddr_i(apu_waddr_i), .apu_wdata_i(apu_wdata_i),
    .apu_ready_o(apu_ready_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i), .hazard_o(hazard_o),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o)
  );
  // rdy/hz are sampled before the edge; the write ports after it
  typedef struct {
    int sb, ex_we, ex_a, ex_d, lsu_we, lsu_a, lsu_d, apu_v, apu_a, apu_d, ra, rb, rc;
    int rdy, hz, we_a, wa_a, wd_a, we_b, wa_b, wd_b;
  } vec_t;
  vec_t vt [25];
  int n_vec = 0, n_err = 0;
  task automatic idle();
    setback_i = 0; ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    apu_valid_i = 0; apu_waddr_i = 0; apu_wdata_i = 0;
    raddr_a_i = 0; raddr_b_i = 0; raddr_c_i = 0;
  endtask
  task automatic apply(input int i);
    int g_rdy, g_hz;
    @(negedge clk);
    setback_i = vt[i].sb != 0;
    ex_we_i = vt[i].ex_we != 0; ex_waddr_i = 6'(vt[i].ex_a); ex_wdata_i = 32'(vt[i].ex_d);
    lsu_we_i = vt[i].lsu_we != 0; lsu_waddr_i = 6'(vt[i].lsu_a); lsu_wdata_i = 32'(vt[i].lsu_d);
    apu_valid_i = vt[i].apu_v != 0; apu_waddr_i = 6'(vt[i].apu_a); apu_wdata_i = 32'(vt[i].apu_d);
    raddr_a_i = 6'(vt[i].ra); raddr_b_i = 6'(vt[i].rb); raddr_c_i = 6'(vt[i].rc);
    #1;
    g_rdy = int'(apu_ready_o);
    g_hz  = int'(hazard_o);
    @(posedge clk);
    #1;
    n_vec++;
    if (g_rdy != vt[i].rdy || g_hz != vt[i].hz ||
        int'(we_a_o) != vt[i].we_a || int'(waddr_a_o) != vt[i].wa_a || int'(wdata_a_o) != vt[i].wd_a ||
        int'(we_b_o) != vt[i].we_b || int'(waddr_b_o) != vt[i].wa_b || int'(wdata_b_o) != vt[i].wd_b) begin
      n_err++;
      $display("FAIL vec%0d: got rdy=%0d hz=%0d A=%0d/%0d/%h B=%0d/%0d/%h, expected rdy=%0d hz=%0d A=%0d/%0d/%h B=%0d/%0d/%h",
               i, g_rdy, g_hz, we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o,
               vt[i].rdy, vt[i].hz, vt[i].we_a, vt[i].wa_a, vt[i].wd_a, vt[i].we_b, vt[i].wa_b, vt[i].wd_b);
    end
  endtask
  task automatic chk_clear(input string name);
    n_vec++;
    if (we_a_o !== 1'b0 || waddr_a_o !== 6'd0 || wdata_a_o !== 32'd0 || we_b_o !== 1'b0 ||
        waddr_b_o !== 6'd0 || wdata_b_o !== 32'd0 || apu_ready_o !== 1'b1 || hazard_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got A=%b/%0d/%h B=%b/%0d/%h rdy=%b hz=%b, expected A=0/0/0 B=0/0/0 rdy=1 hz=0",
               name, we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o, apu_ready_o, hazard_o);
    end
  endtask
  initial begin
    //          sb ex          lsu           apu                 ra rb  rc  rdy hz  A              B
    vt[0]  = '{0, 1,5,'h11,  1,6,'h22,   0,0,0,              0, 0, 0,  1,0,  1,5,'h11,  1,6,'h22};
    vt[1]  = '{0, 0,0,0,     0,0,0,      0,0,0,              5, 0, 0,  1,1,  0,0,0,     0,0,0};
    vt[2]  = '{0, 0,0,0,     1,1,'h100,  1,7,'h7,            0, 0, 0,  1,0,  0,0,0,     1,1,'h100};
    vt[3]  = '{0, 0,0,0,     1,2,'h200,  1,8,'h8,            0, 0, 0,  1,0,  0,0,0,     1,2,'h200};
    vt[4]  = '{0, 0,0,0,     1,3,'h300,  1,9,'h9,            0, 0, 0,  0,0,  0,0,0,     1,3,'h300};
    vt[5]  = '{0, 0,0,0,     1,4,'h400,  1,9,'h9,            0, 0, 0,  0,0,  0,0,0,     1,4,'h400};
    vt[6]  = '{0, 0,0,0,     0,0,0,      1,9,'h9,            0, 0, 0,  0,0,  0,0,0,     1,7,'h7};
    vt[7]  = '{0, 0,0,0,     0,0,0,      1,9,'h9,            0, 0, 0,  1,0,  0,0,0,     1,8,'h8};
    vt[8]  = '{0, 0,0,0,     0,0,0,      0,0,0,              0, 0, 0,  1,0,  0,0,0,     1,9,'h9};
    vt[9]  = '{0, 0,0,0,     0,0,0,      0,0,0,              0, 0, 0,  1,0,  0,0,0,     0,0,0};
    vt[10] = '{0, 1,10,'hA,  0,0,0,      1,10,'hB,           0, 0, 0,  1,0,  1,10,'hA,  0,0,0};
    vt[11] = '{0, 0,0,0,     0,0,0,      0,0,0,              0, 0, 0,  1,0,  0,0,0,     0,0,0};
    vt[12] = '{0, 0,0,0,     0,0,0,      1,0,'h55,           0, 0, 0,  1,0,  0,0,0,     0,0,0};
    vt[13] = '{0, 0,0,0,     0,0,0,      1,32,'h3F800000,    0, 0, 0,  1,0,  0,0,0,     1,32,'h3F800000};
    vt[14] = '{0, 0,0,0,     0,0,0,      0,0,0,              0, 0, 0,  1,0,  0,0,0,     0,0,0};
    vt[15] = '{0, 0,0,0,     1,1,'h1,    1,12,'hC,           0, 12, 0, 1,0,  0,0,0,     1,1,'h1};
    vt[16] = '{0, 0,0,0,     1,2,'h2,    0,0,0,              0, 12, 0, 1,1,  0,0,0,     1,2,'h2};
    vt[17] = '{0, 0,0,0,     0,0,0,      0,0,0,              0, 12, 0, 1,1,  0,0,0,     1,12,'hC};
    vt[18] = '{0, 0,0,0,     0,0,0,      0,0,0,              0, 12, 0, 1,1,  0,0,0,     0,0,0};
    vt[19] = '{0, 0,0,0,     0,0,0,      0,0,0,              0, 12, 0, 1,0,  0,0,0,     0,0,0};
    vt[20] = '{0, 0,0,0,     1,1,'h1,    1,20,'h20,          0, 0, 0,  1,0,  0,0,0,     1,1,'h1};
    vt[21] = '{0, 0,0,0,     1,2,'h2,    1,21,'h21,          0, 0, 0,  1,0,  0,0,0,     1,2,'h2};
    vt[22] = '{1, 1,4,'h4,   1,3,'h3,    1,22,'h22,          20, 0, 0, 0,1,  0,0,0,     0,0,0};
    vt[23] = '{0, 0,0,0,     0,0,0,      0,0,0,              20, 0, 0, 1,0,  0,0,0,     0,0,0};
    vt[24] = '{0, 0,0,0,     0,0,0,      0,0,0,              0, 0, 21, 1,0,  0,0,0,     0,0,0};
    idle();
    repeat (2) @(negedge clk);
    chk_clear("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) apply(i);
    // refill the FIFO, then drop rst_n asynchronously mid-cycle
    apply(20);
    apply(21);
    @(negedge clk);
    #2 rst_n = 1'b0;
    idle();
    #1 chk_clear("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply(23);
    apply(24);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
